dem_bcd_updown_n: RTL and testbench
===================================

# dem_bcd_updown_n

Parametrised multi-digit BCD up/down counter; generalises the single-digit 0–9 / 9–0 counter to N decimal digits with a programmable modulus, synchronous load, enable, wrap-or-saturate mode and a terminal-count pulse. Sits between the board clock and the display driver: seconds/minutes counters, countdown timers and lap counters instantiate it directly. An optional internal prescaler turns the fast board clock into the count tick.

## Interface
- `DIGITS`, default 2: number of BCD digits (1–8).
- `MAX_COUNT`, default 99: highest count value, as a decimal integer; must be below 10^DIGITS.
- `TICK_DIV`, default 50_000_000: clocks per count tick when the prescaler is compiled in (≥2).
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `en`  in  1: count enable.
- `S`  in  1: direction; 0 = up, 1 = down.
- `wrap`  in  1: 1 = wrap at bounds; 0 = saturate at bounds.
- `load`  in  1: synchronous load strobe.
- `load_val`  in  4*DIGITS: BCD value to load.
- `q`  out  4*DIGITS: BCD count, digit 0 in bits [3:0].
- `tc`  out  1: terminal-count pulse, one clock wide.

## Operation
- Reset (`reset`=0, asynchronous): `q`=0, `tc`=0, prescaler=0. Release is synchronous to `clk`.
- step = `en` & tick. tick comes from the prescaler (see Configuration).
- Priority per clock: `load` > step > hold.
- Load: `load_val` is valid only if every digit ≤9 and the value ≤ `MAX_COUNT`. A valid value is written to `q`. An invalid value is ignored and `q` holds. Load always clears the prescaler and forces `tc`=0.
- Up step (`S`=0):
  - `q` < `MAX_COUNT`: BCD increment; digit 9→0 carries into the next digit.
  - `q` = `MAX_COUNT`: wrap=1 gives `q`→0; wrap=0 holds `q`.
- Down step (`S`=1):
  - `q` > 0: BCD decrement; digit 0→9 borrows from the next digit.
  - `q` = 0: wrap=1 gives `q`→`MAX_COUNT`; wrap=0 holds `q`.
- `tc`: set for one cycle on any step taken while `q` sits at the bound in the current direction (`MAX_COUNT` going up, 0 going down), in both wrap and saturate mode. In saturate mode `tc` repeats on every such step.
- `S` and `wrap` are sampled only on the step cycle. A direction change mid-count takes effect on the next step with no glitch.
- `en`=0 freezes `q` but lets the prescaler run. The prescaler is not cleared by `en`.

## Timing
- `q` and `tc` are registered. Both change on the rising edge of the step/load cycle, so latency is one clock.
- `tc` is high in the same cycle that `q` shows the wrapped or held value.
- Asynchronous reset mid-count aborts immediately. After release, the first tick occurs `TICK_DIV` clocks later.
- Simultaneous `load` and step: the load wins, the step is lost, and `tc`=0.
- Prescaler: counts 0..`TICK_DIV`-1; tick is high in the cycle the counter equals `TICK_DIV`-1, then it wraps to 0.

## Configuration
- `DEM_PRESCALER_EN` defined: internal prescaler is built; tick is a one-clock pulse every `TICK_DIV` clocks.
- Not defined: no prescaler logic; tick is tied to 1, so `en` acts as the external step strobe, one step per clock while high. `TICK_DIV` is ignored.

## Structure
- Shared package `dem_pkg`:
  - constants `DIR_UP`=1'b0, `DIR_DOWN`=1'b1, `BCD_DIGIT_MAX`=4'd9;
  - function `to_bcd(int value, int digits)` converting `MAX_COUNT` to packed BCD at elaboration;
  - function `bcd_valid` for load checking.
- Sub-module `bcd_digit`: one-digit increment/decrement with carry/borrow in/out, instantiated `DIGITS` times in a generate loop.
- The top holds the bound compare, load check, `tc` register and prescaler.

## Test plan
All scenarios use `DIGITS`=2, `MAX_COUNT`=59, `TICK_DIV`=4, prescaler enabled.
- Reset, then `en`=1, `S`=0, `wrap`=1 for 60 ticks → `q` steps 00,01…09,10…59,00; `tc`=1 only on the 59→00 step; ticks are 4 clocks apart.
- From 00 with `S`=1, `wrap`=1, one tick → `q`=59, `tc`=1. Next tick → 58, `tc`=0.
- `wrap`=0, load 58, count up 3 ticks → `q` = 59, 59, 59; `tc`=1 on ticks 2 and 3. Repeat going down from 01 → `q` = 00, 00; `tc` on the second tick.
- Loads: load 0x37 → `q`=37. Load 0x3A (bad digit) or 0x60 (>59) → `q` holds 37. Load asserted on a tick cycle → `q`=load value, `tc`=0, next tick 4 clocks later.
- Drive `reset`=0 asynchronously mid-count at `q`=42, between clock edges → `q`=00 immediately. Flip `S` 1→0 at `q`=05 between ticks → next tick gives 06. Build without `DEM_PRESCALER_EN` → `q` advances every clock while `en`=1.

Source files
------------

// File: rtl/dem_pkg.sv
// dem_pkg: shared constants and BCD helpers for the dem_bcd_updown_n counter
// Contents: direction encodings, largest BCD digit, elaboration-time
// integer-to-BCD conversion and a per-digit BCD validity check.
package dem_pkg;
  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DOWN = 1'b1;
  localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;
  function automatic logic [31:0] to_bcd(input int value, input int digits);
    logic [31:0] r = '0;
    int v = value;
    for (int i = 0; i < 8; i++)
      if (i < digits) begin
        r[4*i+:4] = 4'(v % 10);
        v = v / 10;
      end
    return r;
  endfunction
  function automatic logic bcd_valid(input logic [31:0] v, input int digits);
    logic ok = 1'b1;
    for (int i = 0; i < 8; i++)
      if (i < digits && v[4*i+:4] > BCD_DIGIT_MAX) ok = 1'b0;
    return ok;
  endfunction
endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one BCD digit increment/decrement stage with carry/borrow chain
// Ports: d (current digit), down (1 = decrement), ci (carry/borrow in),
//        nd (next digit), co (carry/borrow out: ci and digit rolls over).
module bcd_digit
  import dem_pkg::*;
(
  input  logic [3:0] d,
  input  logic       down,
  input  logic       ci,
  output logic [3:0] nd,
  output logic       co
);
  logic roll;
  always_comb begin
    roll = down ? d == 4'd0 : d == BCD_DIGIT_MAX;
    co = ci & roll;
    nd = !ci ? d : roll ? (down ? BCD_DIGIT_MAX : 4'd0) : down ? d - 4'd1 : d + 4'd1;
  end
endmodule

// File: rtl/dem_bcd_updown_n.sv
// dem_bcd_updown_n: N-digit BCD up/down counter with modulus, load, wrap/saturate and tc
// Ports: clk, reset (async active-low), en (count enable), S (0 up / 1 down),
//        wrap (1 wrap / 0 saturate), load + load_val (BCD synchronous load),
//        q (BCD count, digit 0 in [3:0]), tc (one-clock terminal-count pulse).
// Option: define DEM_PRESCALER_EN to build the TICK_DIV prescaler; otherwise
//         every clock is a tick and en is the step strobe.
module dem_bcd_updown_n
  import dem_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int MAX_COUNT = 99,
  parameter int TICK_DIV = 50_000_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                S,
  input  logic                wrap,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] q,
  output logic                tc
);
  localparam int W = 4 * DIGITS;
  localparam logic [W-1:0] MAX_BCD = W'(to_bcd(MAX_COUNT, DIGITS));
  if (DIGITS < 1 || DIGITS > 8 || MAX_COUNT < 0 || MAX_COUNT >= 10 ** DIGITS || TICK_DIV < 2) begin : g_bad_params
    $error("dem_bcd_updown_n: illegal parameter combination");
  end
  logic tick;
`ifdef DEM_PRESCALER_EN
  localparam int PW = $clog2(TICK_DIV);
  logic [PW-1:0] pre;
  assign tick = pre == PW'(TICK_DIV - 1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) pre <= '0;
    else pre <= (load || tick) ? '0 : pre + 1'b1;
`else
  assign tick = 1'b1;
`endif
  logic [W-1:0] nxt;
  logic [DIGITS:0] c;
  assign c[0] = 1'b1;
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .d   (q[4*i+:4]),
      .down(S),
      .ci  (c[i]),
      .nd  (nxt[4*i+:4]),
      .co  (c[i+1])
    );
  end
  logic step, at_bound, load_ok;
  // Going down, a borrow out of the top digit means q is all zeros.
  always_comb begin
    step = en & tick;
    at_bound = S == DIR_DOWN ? c[DIGITS] : q == MAX_BCD;
    load_ok = bcd_valid(32'(load_val), DIGITS) && load_val <= MAX_BCD;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      q  <= '0;
      tc <= 1'b0;
    end else if (load) begin
      if (load_ok) q <= load_val;
      tc <= 1'b0;
    end else begin
      tc <= step & at_bound;
      if (step) q <= !at_bound ? nxt : !wrap ? q : S == DIR_DOWN ? MAX_BCD : '0;
    end
endmodule

// File: tb/tb_dem_bcd_updown_n.sv
// tb_dem_bcd_updown_n: randomized and directed self-checking bench for dem_bcd_updown_n
module tb_dem_bcd_updown_n;
  localparam int MAXC = 59;
`ifdef DEM_PRESCALER_EN
  localparam int TP = 4;
`else
  localparam int TP = 1;
`endif
  logic clk = 0, reset = 1, en = 0, S = 0, wrap = 0, load = 0;
  logic [7:0] load_val = 0, q;
  logic tc;
  int checks = 0, errors = 0;
  int m_q = 0, m_pre = 0;
  logic m_tc = 0;
  always #5 clk = ~clk;
  dem_bcd_updown_n #(.DIGITS(2), .MAX_COUNT(MAXC), .TICK_DIV(4)) dut (
    .clk(clk), .reset(reset), .en(en), .S(S), .wrap(wrap), .load(load),
    .load_val(load_val), .q(q), .tc(tc)
  );
  function automatic logic [7:0] bcd(input int n);
    return 8'((n / 10) * 16 + n % 10);
  endfunction
  function automatic int dec(input logic [7:0] v);
    int r = 0;
    for (int i = 1; i >= 0; i--) begin
      if (v[4*i+:4] > 4'd9) return -1;
      r = r * 10 + int'(v[4*i+:4]);
    end
    return r;
  endfunction
  always @(posedge clk or negedge reset)
    if (!reset) begin
      m_q <= 0;
      m_tc <= 0;
      m_pre <= 0;
    end else if (load) begin
      m_pre <= 0;
      m_tc <= 0;
      if (dec(load_val) >= 0 && dec(load_val) <= MAXC) m_q <= dec(load_val);
    end else begin
      m_pre <= m_pre == TP - 1 ? 0 : m_pre + 1;
      m_tc <= 0;
      if (en && m_pre == TP - 1) begin
        if (!S) begin
          if (m_q == MAXC) begin m_tc <= 1; if (wrap) m_q <= 0; end
          else m_q <= m_q + 1;
        end else begin
          if (m_q == 0) begin m_tc <= 1; if (wrap) m_q <= MAXC; end
          else m_q <= m_q - 1;
        end
      end
    end
  task automatic test_reset;
    #2 reset = 0;
    #1;
    checks++;
    if (q !== 8'h00 || tc !== 1'b0) begin
      errors++;
      $display("FAIL reset q=%h tc=%b expected q=00 tc=0", q, tc);
    end
  endtask
  task automatic test_count_up;
    int tcs = 0;
    @(negedge clk);
    en = 1; S = 0; wrap = 1; reset = 1;
    for (int i = 0; i < 60 * TP; i++) begin
      @(posedge clk); #1;
      tcs += int'(tc);
      checks++;
      if (q !== bcd(m_q) || tc !== m_tc) begin
        errors++;
        $display("FAIL count_up cyc=%0d q=%h tc=%b expected q=%h tc=%b", i, q, tc, bcd(m_q), m_tc);
      end
    end
    checks++;
    if (q !== 8'h00 || tc !== 1'b1 || tcs != 1) begin
      errors++;
      $display("FAIL count_up_end q=%h tc=%b tcs=%0d expected q=00 tc=1 tcs=1", q, tc, tcs);
    end
  endtask
  task automatic test_down_wrap;
    @(negedge clk);
    S = 1;
    for (int i = 0; i < 2 * TP; i++) begin
      @(posedge clk); #1;
      checks++;
      if (q !== bcd(m_q) || tc !== m_tc) begin
        errors++;
        $display("FAIL down_wrap cyc=%0d q=%h tc=%b expected q=%h tc=%b", i, q, tc, bcd(m_q), m_tc);
      end
      if (i == TP - 1) begin
        checks++;
        if (q !== 8'h59 || tc !== 1'b1) begin
          errors++;
          $display("FAIL down_wrap_59 q=%h tc=%b expected q=59 tc=1", q, tc);
        end
      end
    end
    checks++;
    if (q !== 8'h58 || tc !== 1'b0) begin
      errors++;
      $display("FAIL down_wrap_58 q=%h tc=%b expected q=58 tc=0", q, tc);
    end
  endtask
  task automatic test_saturate;
    for (int p = 0; p < 2; p++) begin
      int tcs = 0;
      @(negedge clk);
      load = 1; load_val = p == 0 ? 8'h58 : 8'h01; wrap = 0; S = p == 1; en = 1;
      @(posedge clk); #1;
      @(negedge clk);
      load = 0;
      for (int i = 0; i < (p == 0 ? 3 : 2) * TP; i++) begin
        @(posedge clk); #1;
        tcs += int'(tc);
        checks++;
        if (q !== bcd(m_q) || tc !== m_tc) begin
          errors++;
          $display("FAIL saturate cyc=%0d q=%h tc=%b expected q=%h tc=%b", i, q, tc, bcd(m_q), m_tc);
        end
        if (i == TP - 1 && p == 0) begin
          checks++;
          if (q !== 8'h59 || tc !== 1'b0) begin
            errors++;
            $display("FAIL saturate_first q=%h tc=%b expected q=59 tc=0", q, tc);
          end
        end
      end
      checks++;
      if (q !== (p == 0 ? 8'h59 : 8'h00) || tcs != (p == 0 ? 2 : 1)) begin
        errors++;
        $display("FAIL saturate_end dir=%0d q=%h tcs=%0d", p, q, tcs);
      end
    end
  endtask
  task automatic test_loads;
    logic [7:0] vals[3] = '{8'h37, 8'h3A, 8'h60};
    en = 0;
    foreach (vals[k]) begin
      @(negedge clk);
      load = 1; load_val = vals[k];
      @(posedge clk); #1;
      checks++;
      if (q !== 8'h37 || tc !== 1'b0) begin
        errors++;
        $display("FAIL load_%h q=%h tc=%b expected q=37 tc=0", vals[k], q, tc);
      end
    end
    @(negedge clk);
    load = 0; en = 1; S = 0; wrap = 1;
    for (int i = 0; i < TP && m_pre != TP - 1; i++) @(negedge clk);
    load = 1; load_val = 8'h21;
    @(posedge clk); #1;
    checks++;
    if (q !== 8'h21 || tc !== 1'b0) begin
      errors++;
      $display("FAIL load_on_tick q=%h tc=%b expected q=21 tc=0", q, tc);
    end
    @(negedge clk);
    load = 0;
    for (int i = 0; i < TP; i++) begin
      @(posedge clk); #1;
      checks++;
      if (q !== (i == TP - 1 ? 8'h22 : 8'h21) || tc !== 1'b0) begin
        errors++;
        $display("FAIL after_load cyc=%0d q=%h tc=%b", i, q, tc);
      end
    end
  endtask
  task automatic test_async_reset;
    @(negedge clk);
    load = 1; load_val = 8'h42; en = 1;
    @(posedge clk); #1;
    @(negedge clk);
    load = 0;
    #2 reset = 0;
    #1;
    checks++;
    if (q !== 8'h00 || tc !== 1'b0) begin
      errors++;
      $display("FAIL async_reset q=%h tc=%b expected q=00 tc=0", q, tc);
    end
    @(negedge clk);
    reset = 1;
  endtask
  task automatic test_flip;
    @(negedge clk);
    load = 1; load_val = 8'h05; S = 1; en = 1; wrap = 1;
    @(posedge clk); #1;
    for (int i = 0; i < TP; i++) begin
      @(negedge clk);
      load = 0; S = i < TP - 1;
      @(posedge clk); #1;
    end
    checks++;
    if (q !== 8'h06 || tc !== 1'b0) begin
      errors++;
      $display("FAIL flip q=%h tc=%b expected q=06 tc=0", q, tc);
    end
  endtask
  task automatic test_random;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      en = $urandom_range(3) != 0;
      S = 1'($urandom_range(1));
      wrap = 1'($urandom_range(1));
      load = $urandom_range(15) == 0;
      load_val = $urandom_range(2) == 0 ? 8'($urandom) : bcd(int'($urandom_range(MAXC)));
      @(posedge clk); #1;
      checks++;
      if (q !== bcd(m_q) || tc !== m_tc) begin
        errors++;
        $display("FAIL random cyc=%0d q=%h tc=%b expected q=%h tc=%b", i, q, tc, bcd(m_q), m_tc);
      end
    end
  endtask
  initial begin
    test_reset;
    test_count_up;
    test_down_wrap;
    test_saturate;
    test_loads;
    test_async_reset;
    test_flip;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
